// File: rtl/hsv_to_rgb_pipe.sv
// Four-stage HSV to RGB converter with valid/ready handshaking on both sides.
// The pipeline advances as a whole; downstream backpressure freezes every stage.
module hsv_to_rgb_pipe #(
  parameter int IN_W     = 9,
  parameter int OUT_W    = 8,
  parameter int CH_ORDER = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  hue,
  input  logic [IN_W-1:0]  sat,
  input  logic [IN_W-1:0]  val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_c0,
  output logic [OUT_W-1:0] out_c1,
  output logic [OUT_W-1:0] out_c2,
  output logic             out_clamped
);

  localparam int MAXV = 2**OUT_W - 1;
  localparam int PW   = OUT_W + 8;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: range normalisation and hue split into sector / fraction.
  logic [31:0] hue_w, sat_w, val_w, h_w;
  logic [2:0]  sector_next;
  logic [5:0]  f_next;
  logic [6:0]  s_next, v_next;
  logic        clamp_next;

  always_comb begin
    hue_w = 32'(hue);
    sat_w = 32'(sat);
    val_w = 32'(val);
    if (hue_w >= 32'd720)
      h_w = hue_w - 32'd720;
    else if (hue_w >= 32'd360)
      h_w = hue_w - 32'd360;
    else
      h_w = hue_w;
    // Very wide hue inputs can still leave h >= 360; pin those to sector 5.
    sector_next = (h_w >= 32'd360) ? 3'd5 : 3'(h_w / 32'd60);
    f_next      = 6'(h_w % 32'd60);
    s_next      = (sat_w > 32'd100) ? 7'd100 : 7'(sat);
    v_next      = (val_w > 32'd100) ? 7'd100 : 7'(val);
    clamp_next  = (hue_w >= 32'd360) || (sat_w > 32'd100) || (val_w > 32'd100);
  end

  logic       s1_valid_reg, s1_clamp_reg;
  logic [2:0] s1_sector_reg;
  logic [5:0] s1_f_reg;
  logic [6:0] s1_s_reg, s1_v_reg;

  // Stage 2: minimum channel level.
  logic [13:0] vmin_prod;
  logic [6:0]  vmin_next;
  assign vmin_prod = 14'(7'd100 - s1_s_reg) * 14'(s1_v_reg);
  assign vmin_next = 7'(vmin_prod / 14'd100);

  logic       s2_valid_reg, s2_clamp_reg;
  logic [2:0] s2_sector_reg;
  logic [5:0] s2_f_reg;
  logic [6:0] s2_v_reg, s2_vmin_reg;

  // Stage 3: rising and falling ramp levels within the sector.
  logic [12:0] a_prod;
  logic [6:0]  a_val, vinc_next, vdec_next;
  assign a_prod    = 13'(s2_v_reg - s2_vmin_reg) * 13'(s2_f_reg);
  assign a_val     = 7'(a_prod / 13'd60);
  assign vinc_next = s2_vmin_reg + a_val;
  assign vdec_next = s2_v_reg - a_val;

  logic       s3_valid_reg, s3_clamp_reg;
  logic [2:0] s3_sector_reg;
  logic [6:0] s3_v_reg, s3_vmin_reg, s3_vinc_reg, s3_vdec_reg;

  // Stage 4: percent to channel scale with round-half-up, then sector mapping.
  function automatic logic [OUT_W-1:0] scale(input logic [6:0] x);
    logic [PW-1:0] t;
    t = PW'(x) * PW'(MAXV) + PW'(50);
    return OUT_W'(t / PW'(100));
  endfunction

  logic [6:0]       lvl [4];
  logic [OUT_W-1:0] q   [4];
  assign lvl[0] = s3_v_reg;
  assign lvl[1] = s3_vinc_reg;
  assign lvl[2] = s3_vdec_reg;
  assign lvl[3] = s3_vmin_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scale
      assign q[gi] = scale(lvl[gi]);
    end
  endgenerate

  logic [OUT_W-1:0] r_next, g_next, b_next, c0_next, c2_next;

  always_comb begin
    r_next = q[0];
    g_next = q[3];
    b_next = q[2];
    case (s3_sector_reg)
      3'd0: begin r_next = q[0]; g_next = q[1]; b_next = q[3]; end
      3'd1: begin r_next = q[2]; g_next = q[0]; b_next = q[3]; end
      3'd2: begin r_next = q[3]; g_next = q[0]; b_next = q[1]; end
      3'd3: begin r_next = q[3]; g_next = q[2]; b_next = q[0]; end
      3'd4: begin r_next = q[1]; g_next = q[3]; b_next = q[0]; end
      default: begin r_next = q[0]; g_next = q[3]; b_next = q[2]; end
    endcase
    c0_next = (CH_ORDER == 1) ? b_next : r_next;
    c2_next = (CH_ORDER == 1) ? r_next : b_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_clamp_reg  <= 1'b0;
      s1_sector_reg <= '0;
      s1_f_reg      <= '0;
      s1_s_reg      <= '0;
      s1_v_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      s2_clamp_reg  <= 1'b0;
      s2_sector_reg <= '0;
      s2_f_reg      <= '0;
      s2_v_reg      <= '0;
      s2_vmin_reg   <= '0;
      s3_valid_reg  <= 1'b0;
      s3_clamp_reg  <= 1'b0;
      s3_sector_reg <= '0;
      s3_v_reg      <= '0;
      s3_vmin_reg   <= '0;
      s3_vinc_reg   <= '0;
      s3_vdec_reg   <= '0;
      out_valid     <= 1'b0;
      out_clamped   <= 1'b0;
      out_c0        <= '0;
      out_c1        <= '0;
      out_c2        <= '0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid;
      s1_clamp_reg  <= clamp_next;
      s1_sector_reg <= sector_next;
      s1_f_reg      <= f_next;
      s1_s_reg      <= s_next;
      s1_v_reg      <= v_next;
      s2_valid_reg  <= s1_valid_reg;
      s2_clamp_reg  <= s1_clamp_reg;
      s2_sector_reg <= s1_sector_reg;
      s2_f_reg      <= s1_f_reg;
      s2_v_reg      <= s1_v_reg;
      s2_vmin_reg   <= vmin_next;
      s3_valid_reg  <= s2_valid_reg;
      s3_clamp_reg  <= s2_clamp_reg;
      s3_sector_reg <= s2_sector_reg;
      s3_v_reg      <= s2_v_reg;
      s3_vmin_reg   <= s2_vmin_reg;
      s3_vinc_reg   <= vinc_next;
      s3_vdec_reg   <= vdec_next;
      out_valid     <= s3_valid_reg;
      out_clamped   <= s3_clamp_reg;
      out_c0        <= c0_next;
      out_c1        <= g_next;
      out_c2        <= c2_next;
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// Directed bench: an RGB-order and a BGR-order instance share stimulus and are
// scored against hand-computed colours through one in-order expectation queue.
module tb_hsv_to_rgb_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [8:0] hue = '0, sat = '0, val = '0;

  logic       in_ready, out_valid, out_clamped;
  logic [7:0] out_c0, out_c1, out_c2;
  logic       in_ready1, out_valid1, out_clamped1;
  logic [7:0] bgr_c0, bgr_c1, bgr_c2;

  always #5 clk = ~clk;

  hsv_to_rgb_pipe #(.IN_W(9), .OUT_W(8), .CH_ORDER(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .hue(hue), .sat(sat), .val(val), .out_valid(out_valid), .out_ready(out_ready),
    .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2), .out_clamped(out_clamped)
  );

  hsv_to_rgb_pipe #(.IN_W(9), .OUT_W(8), .CH_ORDER(1)) dut_bgr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .hue(hue), .sat(sat), .val(val), .out_valid(out_valid1), .out_ready(out_ready),
    .out_c0(bgr_c0), .out_c1(bgr_c1), .out_c2(bgr_c2), .out_clamped(out_clamped1)
  );

  typedef struct {
    logic [8:0]  h;
    logic [24:0] e;   // {clamped, R, G, B}
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int total = 0;
  int bad = 0;
  int run = 0;
  int max_run = 0;
  logic        hold_prev = 1'b0;
  logic [24:0] prev_out = '0;

  logic [8:0]  vh [16];
  logic [8:0]  vs [16];
  logic [8:0]  vv [16];
  logic [24:0] ve [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic send(input int idx);
    logic acc;
    acc = 1'b0;
    hue = vh[idx];
    sat = vs[idx];
    val = vv[idx];
    cur.h = vh[idx];
    cur.e = ve[idx];
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Output monitor / scoreboard, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        hold_prev = 1'b0;
        run = 0;
      end else begin
        if (hold_prev)
          check("hold", {out_valid, out_clamped, out_c0, out_c1, out_c2}, {1'b1, prev_out});
        if (out_valid && !out_ready) begin
          check("in_ready_stall", 32'(in_ready), 32'd0);
          hold_prev = 1'b1;
          prev_out = {out_clamped, out_c0, out_c1, out_c2};
        end else begin
          hold_prev = 1'b0;
        end
        if (out_valid && out_ready) begin
          run++;
          if (run > max_run) max_run = run;
          check("in_ready_flow", 32'(in_ready), 32'd1);
          if (exp_q.size() == 0) begin
            check("extra_output", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            $display("pix hue=%0d rgb=%0h bgr=%0h exp=%0h", e.h,
                     {out_clamped, out_c0, out_c1, out_c2},
                     {out_clamped1, bgr_c0, bgr_c1, bgr_c2}, e.e);
            check("rgb", {out_clamped, out_c0, out_c1, out_c2}, e.e);
            check("bgr", {out_clamped1, bgr_c0, bgr_c1, bgr_c2},
                  {e.e[24], e.e[7:0], e.e[15:8], e.e[23:16]});
          end
        end else begin
          run = 0;
        end
        if (in_valid && in_ready) exp_q.push_back(cur);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    vh = '{9'd0,   9'd30,  9'd120, 9'd200, 9'd400, 9'd0,   9'd359, 9'd360,
           9'd180, 9'd250, 9'd90,  9'd300, 9'd100, 9'd511, 9'd60,  9'd480};
    vs = '{9'd100, 9'd100, 9'd100, 9'd0,   9'd120, 9'd100, 9'd100, 9'd100,
           9'd50,  9'd40,  9'd100, 9'd100, 9'd100, 9'd100, 9'd100, 9'd100};
    vv = '{9'd100, 9'd100, 9'd50,  9'd100, 9'd100, 9'd0,   9'd100, 9'd100,
           9'd80,  9'd90,  9'd100, 9'd100, 9'd101, 9'd100, 9'd100, 9'd100};
    ve = '{{1'b0, 8'd255, 8'd0,   8'd0},
           {1'b0, 8'd255, 8'd128, 8'd0},
           {1'b0, 8'd0,   8'd128, 8'd0},
           {1'b0, 8'd255, 8'd255, 8'd255},
           {1'b1, 8'd255, 8'd168, 8'd0},
           {1'b0, 8'd0,   8'd0,   8'd0},
           {1'b0, 8'd255, 8'd0,   8'd5},
           {1'b1, 8'd255, 8'd0,   8'd0},
           {1'b0, 8'd102, 8'd204, 8'd204},
           {1'b0, 8'd153, 8'd138, 8'd230},
           {1'b0, 8'd128, 8'd255, 8'd0},
           {1'b0, 8'd255, 8'd0,   8'd255},
           {1'b1, 8'd87,  8'd255, 8'd0},
           {1'b1, 8'd0,   8'd255, 8'd130},
           {1'b0, 8'd255, 8'd255, 8'd0},
           {1'b1, 8'd0,   8'd255, 8'd0}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {out_valid, out_clamped, out_c0, out_c1, out_c2}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency from the accepting edge to out_valid.
    send(0);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    drain();

    // Every vector in isolation, with idle cycles between.
    for (int i = 0; i < 16; i++) begin
      send(i);
      drain();
    end

    // Back-to-back stream of eight pixels.
    max_run = 0;
    for (int i = 0; i < 8; i++) send(i);
    drain();
    check("stream_run", max_run, 8);

    // Five cycles of backpressure in the middle of a stream.
    fork
      begin
        for (int i = 8; i < 16; i++) send(i);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with pixels in flight: one at the output, three behind it.
    for (int i = 1; i < 5; i++) send(i);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out", {out_valid, out_clamped, out_c0, out_c1, out_c2}, 32'd0);
    check("mid_rst_bgr", {out_valid1, out_clamped1, bgr_c0, bgr_c1, bgr_c2}, 32'd0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("no_ghost", 32'(out_valid), 32'd0);

    send(13);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
